// File: rtl/vga_pkg.sv
// Shared timing constants, colours and the tile-map address helper for the VGA pixel pipe.
package vga_pkg;

    localparam int H_START = 256;
    localparam int V_START = 36;
    localparam int ACT_W   = 640;
    localparam int ACT_H   = 480;
    localparam int LAT     = 4;
    localparam int TILE    = 8;
    localparam int MAP_W   = 80;

    localparam logic [11:0] BG_COLOUR  = 12'h114;
    localparam logic [11:0] SPR_COLOUR = 12'hF20;
    localparam logic [11:0] FG_PAL [0:3] = '{12'hFFF, 12'h0F4, 12'h4AF, 12'hFC0};

    // row*80 + col built from shifts so no multiplier is needed
    function automatic logic [12:0] map_addr(input logic [5:0] ty, input logic [6:0] tx);
        return ({7'd0, ty} << 6) + ({7'd0, ty} << 4) + {6'd0, tx};
    endfunction

endpackage

// File: rtl/vga_sprite_unit.sv
// Ant sprite: shadow/live position with once-per-frame update, hit test and row fetch.
// Only compiled when ANT_SPRITE_EN is defined.
`ifdef ANT_SPRITE_EN
module vga_sprite_unit
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_start_i,
    input  logic [9:0]  pos_x_i,
    input  logic [8:0]  pos_y_i,
    input  logic        pos_valid_i,
    output logic        pos_ready_o,
    input  logic [9:0]  x1_i,
    input  logic [8:0]  y1_i,
    input  logic        act1_i,
    output logic [3:0]  spr_addr_o,
    input  logic [15:0] spr_data_i,
    output logic        spr_pix_o
);

    logic [9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [9:0] sx_q, sx_d, sy_q, sy_d;
    logic       full_q, full_d;
    logic [9:0] dx_s, dy_s;
    logic       hit1_s;
    logic       hit2_q;
    logic [3:0] col2_q;

    // Shadow load and frame-start transfer; a full shadow blocks new loads
    always_comb begin
        sh_x_d = sh_x_q;
        sh_y_d = sh_y_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        full_d = full_q;
        if (frame_start_i && full_q) begin
            sx_d   = sh_x_q;
            sy_d   = sh_y_q;
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (pos_valid_i && !full_q) begin
            sh_x_d = pos_x_i;
            sh_y_d = {1'b0, pos_y_i};
            full_d = 1'b1;
        end else begin
            sh_x_d = sh_x_d;
        end
    end

    // Unsigned differences wrap for negative offsets, so a single compare covers both bounds
    always_comb begin
        dx_s       = x1_i - sx_q;
        dy_s       = {1'b0, y1_i} - sy_q;
        hit1_s     = act1_i && (sx_q < 10'(ACT_W)) && (sy_q < 10'(ACT_H))
                     && (dx_s < 10'd16) && (dy_s < 10'd16);
        spr_addr_o = hit1_s ? dy_s[3:0] : 4'd0;
        spr_pix_o  = hit2_q && spr_data_i[4'd15 - col2_q];
    end

    assign pos_ready_o = !full_q;

    // Position registers and stage-2 hit/column
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_x_q <= 10'd0;
            sh_y_q <= 10'd0;
            sx_q   <= 10'h3FF;
            sy_q   <= 10'h3FF;
            full_q <= 1'b0;
            hit2_q <= 1'b0;
            col2_q <= 4'd0;
        end else begin
            sh_x_q <= sh_x_d;
            sh_y_q <= sh_y_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            full_q <= full_d;
            hit2_q <= hit1_s;
            col2_q <= dx_s[3:0];
        end
    end

endmodule
`endif

// File: rtl/vga_pixel_pipe.sv
// Scan counters to registered 12-bit RGB: tile background plus an optional ant sprite (ANT_SPRITE_EN).
// MAP_ADDR/PAT_ADDR are driven combinationally so two synchronous memory reads fit the 4-cycle latency.
module vga_pixel_pipe
    import vga_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [10:0] HCNT,
    input  logic [9:0]  VCNT,
    input  logic        HSYNC_IN,
    input  logic        VSYNC_IN,
    output logic [12:0] MAP_ADDR,
    input  logic [7:0]  MAP_DATA,
    output logic [8:0]  PAT_ADDR,
    input  logic [7:0]  PAT_DATA,
    input  logic [9:0]  POS_X,
    input  logic [8:0]  POS_Y,
    input  logic        POS_VALID,
    output logic        POS_READY,
    output logic [3:0]  SPR_ADDR,
    input  logic [15:0] SPR_DATA,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        FRAME_TICK
);

    logic [10:0] hx_s;
    logic [9:0]  vy_s;
    logic [9:0]  x0_s;
    logic [8:0]  y0_s;
    logic        act0_s, frame_start_s;
    logic        act1_q, hs1_q, vs1_q;
    logic [9:0]  x1_q;
    logic [8:0]  y1_q;
    logic        act2_q, hs2_q, vs2_q;
    logic [2:0]  xb2_q;
    logic [1:0]  pal2_q;
    logic        bg_on_s, spr_pix_s;
    logic        act3_q, bg3_q, spr3_q, hs3_q, vs3_q;
    logic [1:0]  pal3_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, tick_q;
    logic        unused_s;

    // Stage 0: active window, local coordinates and tile-map address
    always_comb begin
        hx_s          = HCNT - 11'(H_START);
        vy_s          = VCNT - 10'(V_START);
        x0_s          = hx_s[9:0];
        y0_s          = vy_s[8:0];
        act0_s        = (HCNT >= 11'(H_START)) && (HCNT < 11'(H_START + ACT_W))
                        && (VCNT >= 10'(V_START)) && (VCNT < 10'(V_START + ACT_H));
        frame_start_s = (HCNT == 11'd0) && (VCNT == 10'd0);
        if (act0_s) begin
            MAP_ADDR = map_addr(y0_s[8:3], x0_s[9:3]);
        end else begin
            MAP_ADDR = 13'd0;
        end
    end

    // Stage 1 pattern address and stage 2 background bit
    always_comb begin
        if (act1_q) begin
            PAT_ADDR = {MAP_DATA[5:0], y1_q[2:0]};
        end else begin
            PAT_ADDR = 9'd0;
        end
        bg_on_s = PAT_DATA[3'd7 - xb2_q];
    end

`ifdef ANT_SPRITE_EN
    vga_sprite_unit u_sprite (
        .clk_i         (CLK),
        .rst_ni        (RST_N),
        .frame_start_i (frame_start_s),
        .pos_x_i       (POS_X),
        .pos_y_i       (POS_Y),
        .pos_valid_i   (POS_VALID),
        .pos_ready_o   (POS_READY),
        .x1_i          (x1_q),
        .y1_i          (y1_q),
        .act1_i        (act1_q),
        .spr_addr_o    (SPR_ADDR),
        .spr_data_i    (SPR_DATA),
        .spr_pix_o     (spr_pix_s)
    );
    assign unused_s = ^{hx_s[10], vy_s[9]};
`else
    assign POS_READY = 1'b0;
    assign SPR_ADDR  = 4'd0;
    assign spr_pix_s = 1'b0;
    assign unused_s  = ^{hx_s[10], vy_s[9], POS_X, POS_Y, POS_VALID, SPR_DATA, x1_q, y1_q};
`endif

    // Stage 3 colour select: sprite over foreground over background, blank outside the window
    always_comb begin
        rgb_d = 12'h000;
        if (act3_q) begin
            if (spr3_q) begin
                rgb_d = SPR_COLOUR;
            end else if (bg3_q) begin
                rgb_d = FG_PAL[pal3_q];
            end else begin
                rgb_d = BG_COLOUR;
            end
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Pipeline registers; syncs travel alongside so every output shares the same latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            act1_q <= 1'b0;  x1_q  <= 10'd0; y1_q   <= 9'd0;  hs1_q <= 1'b1; vs1_q <= 1'b1;
            act2_q <= 1'b0;  xb2_q <= 3'd0;  pal2_q <= 2'd0;  hs2_q <= 1'b1; vs2_q <= 1'b1;
            act3_q <= 1'b0;  bg3_q <= 1'b0;  spr3_q <= 1'b0;  pal3_q <= 2'd0;
            hs3_q  <= 1'b1;  vs3_q <= 1'b1;
            rgb_q  <= 12'h000; hs_q <= 1'b1; vs_q <= 1'b1;   tick_q <= 1'b0;
        end else begin
            act1_q <= act0_s;  x1_q  <= x0_s;      y1_q   <= y0_s;
            hs1_q  <= HSYNC_IN; vs1_q <= VSYNC_IN;
            act2_q <= act1_q;  xb2_q <= x1_q[2:0]; pal2_q <= MAP_DATA[7:6];
            hs2_q  <= hs1_q;   vs2_q <= vs1_q;
            act3_q <= act2_q;  bg3_q <= bg_on_s;   spr3_q <= spr_pix_s; pal3_q <= pal2_q;
            hs3_q  <= hs2_q;   vs3_q <= vs2_q;
            rgb_q  <= rgb_d;   hs_q  <= hs3_q;     vs_q   <= vs3_q;    tick_q <= frame_start_s;
        end
    end

    assign R          = rgb_q[11:8];
    assign G          = rgb_q[7:4];
    assign B          = rgb_q[3:0];
    assign HSYNC      = hs_q;
    assign VSYNC      = vs_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: vector table, hand sequences and random scan vs a pixel-level model.
module tb_vga_pixel_pipe;
    import vga_pkg::*;

`ifdef ANT_SPRITE_EN
    localparam bit SPR_EN = 1'b1;
`else
    localparam bit SPR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [10:0] HCNT;
    logic [9:0]  VCNT;
    logic        HSYNC_IN, VSYNC_IN;
    logic [12:0] MAP_ADDR;
    logic [7:0]  MAP_DATA;
    logic [8:0]  PAT_ADDR;
    logic [7:0]  PAT_DATA;
    logic [9:0]  POS_X;
    logic [8:0]  POS_Y;
    logic        POS_VALID, POS_READY;
    logic [3:0]  SPR_ADDR;
    logic [15:0] SPR_DATA;
    logic [3:0]  R, G, B;
    logic        HSYNC, VSYNC, FRAME_TICK;

    vga_pixel_pipe dut (
        .CLK(CLK), .RST_N(RST_N), .HCNT(HCNT), .VCNT(VCNT),
        .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .MAP_ADDR(MAP_ADDR), .MAP_DATA(MAP_DATA), .PAT_ADDR(PAT_ADDR), .PAT_DATA(PAT_DATA),
        .POS_X(POS_X), .POS_Y(POS_Y), .POS_VALID(POS_VALID), .POS_READY(POS_READY),
        .SPR_ADDR(SPR_ADDR), .SPR_DATA(SPR_DATA),
        .R(R), .G(G), .B(B), .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  map_mem [0:8191];
    logic [7:0]  pat_mem [0:511];
    logic [15:0] spr_mem [0:15];

    always @(posedge CLK) begin
        MAP_DATA <= map_mem[MAP_ADDR];
        PAT_DATA <= pat_mem[PAT_ADDR];
        SPR_DATA <= spr_mem[SPR_ADDR];
    end

    typedef struct { logic [11:0] rgb; logic hs; logic vs; } out_t;
    out_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   live_x, live_y, sh_x, sh_y;
    bit   sh_full;

    typedef struct { int h; int v; logic [12:0] map; logic [8:0] pat; logic [11:0] rgb; } vec_t;
    vec_t tbl [0:5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit in_window(input int h, input int v);
        return (h >= 256) && (h < 896) && (v >= 36) && (v < 516);
    endfunction

    function automatic logic [11:0] ref_pixel(input int h, input int v, input int sx, input int sy);
        int x, y, glyph, pal;
        logic [7:0]  t, row;
        logic [15:0] srow;
        if (!in_window(h, v)) return 12'h000;
        x     = h - 256;
        y     = v - 36;
        t     = map_mem[(y / 8) * 80 + x / 8];
        glyph = int'(t[5:0]);
        pal   = int'(t[7:6]);
        row   = pat_mem[glyph * 8 + y % 8];
        if (SPR_EN && sx < 640 && sy < 480 && x >= sx && x < sx + 16 && y >= sy && y < sy + 16) begin
            srow = spr_mem[y - sy];
            if (srow[15 - (x - sx)]) return SPR_COLOUR;
        end
        if (row[7 - x % 8]) return FG_PAL[pal];
        return BG_COLOUR;
    endfunction

    task automatic reset_model();
        out_t blank;
        blank.rgb = 12'h000; blank.hs = 1'b1; blank.vs = 1'b1;
        expq.delete();
        repeat (3) expq.push_back(blank);
        live_x = 1023; live_y = 1023; sh_full = 1'b0;
    endtask

    task automatic step(input int h, input int v, input bit pv, input int px, input int py);
        out_t e, o;
        bit   fs, ld;
        int   ema;
        HCNT = 11'(h); VCNT = 10'(v);
        HSYNC_IN = 1'($urandom_range(0, 1)); VSYNC_IN = 1'($urandom_range(0, 1));
        POS_VALID = pv; POS_X = 10'(px); POS_Y = 9'(py);
        #1;
        ema = in_window(h, v) ? ((v - 36) / 8) * 80 + (h - 256) / 8 : 0;
        check("map_addr", 32'(MAP_ADDR), 32'(ema));
        check("pos_ready", 32'(POS_READY), 32'(SPR_EN && !sh_full));
        fs = (h == 0) && (v == 0);
        ld = pv && SPR_EN && !sh_full;
        if (fs && sh_full) begin
            live_x = sh_x; live_y = sh_y; sh_full = 1'b0;
        end
        if (ld) begin
            sh_x = px; sh_y = py; sh_full = 1'b1;
        end
        e.rgb = ref_pixel(h, v, live_x, live_y); e.hs = HSYNC_IN; e.vs = VSYNC_IN;
        expq.push_back(e);
        @(posedge CLK); #1;
        o = expq.pop_front();
        check("rgb", 32'({R, G, B}), 32'(o.rgb));
        check("hsync", 32'(HSYNC), 32'(o.hs));
        check("vsync", 32'(VSYNC), 32'(o.vs));
        check("frame_tick", 32'(FRAME_TICK), 32'(fs));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 1'b0, 0, 0);
    endtask

    task automatic scan_row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v, 1'b0, 0, 0);
    endtask

    initial begin
        int h, v, px, py;
        for (int i = 0; i < 8192; i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i++)  pat_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++)   spr_mem[i] = 16'($urandom);
        spr_mem[0]    = 16'hA5C3;
        map_mem[82]   = 8'h45;
        pat_mem[41]   = 8'b0100_0000;
        map_mem[4799] = 8'hC3;
        pat_mem[31]   = 8'h01;
        map_mem[0]    = 8'h80;
        pat_mem[0]    = 8'h80;

        tbl[0] = '{273, 45,  13'd82,   9'd41, FG_PAL[1]};
        tbl[1] = '{272, 45,  13'd82,   9'd41, BG_COLOUR};
        tbl[2] = '{255, 45,  13'd0,    9'd0,  12'h000};
        tbl[3] = '{896, 45,  13'd0,    9'd0,  12'h000};
        tbl[4] = '{300, 516, 13'd0,    9'd0,  12'h000};
        tbl[5] = '{895, 515, 13'd4799, 9'd31, FG_PAL[3]};

        RST_N = 1'b0; HCNT = 11'd0; VCNT = 10'd0; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
        POS_VALID = 1'b0; POS_X = 10'd0; POS_Y = 9'd0;
        reset_model();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rgb", 32'({R, G, B}), 32'h0);
        check("rst_hsync", 32'(HSYNC), 32'h1);
        check("rst_vsync", 32'(VSYNC), 32'h1);
        check("rst_tick", 32'(FRAME_TICK), 32'h0);
        check("rst_ready", 32'(POS_READY), 32'(SPR_EN));
        check("rst_map_addr", 32'(MAP_ADDR), 32'h0);
        check("rst_pat_addr", 32'(PAT_ADDR), 32'h0);
        check("rst_spr_addr", 32'(SPR_ADDR), 32'h0);
        RST_N = 1'b1;

        step(0, 0, 1'b0, 0, 0);
        idle(6);

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].h, tbl[i].v, 1'b0, 0, 0);
            check($sformatf("tbl%0d_pat_addr", i), 32'(PAT_ADDR), 32'(tbl[i].pat));
            idle(2);
            step(0, 1, 1'b0, 0, 0);
            check($sformatf("tbl%0d_rgb", i), 32'({R, G, B}), 32'(tbl[i].rgb));
        end

        step(300, 100, 1'b1, 100, 50);
        check("stall_ready", 32'(POS_READY), 32'h0);
        scan_row(86, 350, 376);
        step(0, 1, 1'b1, 632, 50);
        step(0, 0, 1'b0, 0, 0);
        scan_row(86, 350, 376);
        scan_row(87, 350, 376);
        step(356, 86, 1'b0, 0, 0);
        idle(3);
`ifdef ANT_SPRITE_EN
        check("spr_left_pixel", 32'({R, G, B}), 32'(SPR_COLOUR));
`endif
        step(300, 200, 1'b1, 632, 50);
        step(0, 0, 1'b0, 0, 0);
        scan_row(86, 880, 900);
        step(895, 86, 1'b0, 0, 0);
        idle(3);
`ifdef ANT_SPRITE_EN
        check("spr_clip_pixel", 32'({R, G, B}), 32'(SPR_COLOUR));
`endif
        step(300, 200, 1'b1, 700, 50);
        step(0, 0, 1'b0, 0, 0);
        scan_row(86, 880, 900);
        step(300, 200, 1'b1, 1020, 20);
        step(0, 0, 1'b0, 0, 0);
        scan_row(57, 250, 280);

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                RST_N = 1'b0;
                #2;
                check("midrst_rgb", 32'({R, G, B}), 32'h0);
                check("midrst_hsync", 32'(HSYNC), 32'h1);
                reset_model();
                RST_N = 1'b1;
            end
            if (i % 300 == 299) begin
                step(0, 0, 1'b0, 0, 0);
            end else begin
                if ($urandom_range(0, 1) == 1 && live_x < 640 && live_y < 480) begin
                    h = 256 + live_x + int'($urandom_range(0, 19)) - 2;
                    v = 36 + live_y + int'($urandom_range(0, 19)) - 2;
                end else if ($urandom_range(0, 4) != 0) begin
                    h = 256 + int'($urandom_range(0, 639));
                    v = 36 + int'($urandom_range(0, 479));
                end else begin
                    h = int'($urandom_range(1, 1086));
                    v = int'($urandom_range(0, 518));
                end
                px = int'($urandom_range(0, 700));
                py = int'($urandom_range(0, 500));
                step(h, v, ($urandom_range(0, 7) == 0), px, py);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
